// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Build option: KEYPAD_OVERRUN_EN (see keypad_scanner.sv).
package keypad_pkg;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;
   localparam logic [3:0] COL_RESET = 4'b1110;

   typedef logic [1:0] kp_state_t;
   localparam kp_state_t SCAN     = 2'd0;
   localparam kp_state_t DEBOUNCE = 2'd1;
   localparam kp_state_t HOLD     = 2'd2;
   localparam kp_state_t RELEASE  = 2'd3;

   // Active-low column drive for a column index: COL_RESET rotated left.
   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      logic [7:0] dbl;
      dbl = {COL_RESET, COL_RESET} << idx;
      return dbl[7:4];
   endfunction

   function automatic logic [1:0] lowest_low_row(input logic [3:0] row);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (!row[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_sync.sv
// Brings the divided scan clock into the CLKIN domain as data and
// produces a one-cycle tick on each of its rising edges.
module scan_tick_sync (
   input  logic CLKIN,
   input  logic ACLR,
   input  logic SCANCLK,
   output logic tick
);

   logic sync1_q, sync2_q, sync3_q;

   always_ff @(posedge CLKIN or posedge ACLR) begin
      if (ACLR) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= SCANCLK;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign tick = sync2_q & ~sync3_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, press/release debounce, valid/ack output.
// Build option: define KEYPAD_OVERRUN_EN to drop keys arriving while one is pending.
//
// state    | meaning
// SCAN     | walking columns, no contact seen
// DEBOUNCE | contact seen, counting stable-low ticks before accepting
// HOLD     | key accepted, waiting for the latched row to go high
// RELEASE  | row high, counting stable-high ticks before rescanning
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       CLKIN,
   input  logic       ACLR,
   input  logic       SCANCLK,
   input  logic [3:0] ROW,
   output logic [3:0] COL,
   output logic [3:0] KEYCODE,
   output logic       KEYVALID,
   input  logic       KEYACK
`ifdef KEYPAD_OVERRUN_EN
   ,
   output logic       OVERRUN
`endif
);

   localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);

   logic       tick;
   kp_state_t  state_q, state_nxt;
   logic [1:0] col_q, col_nxt;
   logic [1:0] row_q, row_nxt;
   logic [3:0] cnt_q, cnt_nxt;
   logic       accept;
   logic [3:0] key_nxt;
   logic       row_hit;
   logic [3:0] keycode_q;
   logic       keyvalid_q;

   scan_tick_sync u_tick (
      .CLKIN   (CLKIN),
      .ACLR    (ACLR),
      .SCANCLK (SCANCLK),
      .tick    (tick)
   );

   assign row_hit = ~ROW[row_q];

   always_comb begin
      state_nxt = state_q;
      col_nxt   = col_q;
      row_nxt   = row_q;
      cnt_nxt   = cnt_q;
      accept    = 1'b0;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (ROW != 4'hF) begin
                  row_nxt = lowest_low_row(ROW);
                  if (DT == 4'd1) begin
                     accept    = 1'b1;
                     cnt_nxt   = 4'd0;
                     state_nxt = HOLD;
                  end else begin
                     cnt_nxt   = 4'd1;
                     state_nxt = DEBOUNCE;
                  end
               end else begin
                  col_nxt = col_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (row_hit) begin
                  if (cnt_q + 4'd1 == DT) begin
                     accept    = 1'b1;
                     cnt_nxt   = 4'd0;
                     state_nxt = HOLD;
                  end else begin
                     cnt_nxt = cnt_q + 4'd1;
                  end
               end else begin
                  cnt_nxt   = 4'd0;
                  col_nxt   = col_q + 2'd1;
                  state_nxt = SCAN;
               end
            end
            HOLD: begin
               if (!row_hit) begin
                  if (DT == 4'd1) begin
                     cnt_nxt   = 4'd0;
                     col_nxt   = col_q + 2'd1;
                     state_nxt = SCAN;
                  end else begin
                     cnt_nxt   = 4'd1;
                     state_nxt = RELEASE;
                  end
               end
            end
            RELEASE: begin
               // A low blip here returns to HOLD without emitting another key.
               if (!row_hit) begin
                  if (cnt_q + 4'd1 == DT) begin
                     cnt_nxt   = 4'd0;
                     col_nxt   = col_q + 2'd1;
                     state_nxt = SCAN;
                  end else begin
                     cnt_nxt = cnt_q + 4'd1;
                  end
               end else begin
                  cnt_nxt   = 4'd0;
                  state_nxt = HOLD;
               end
            end
            default: begin
               cnt_nxt   = 4'd0;
               state_nxt = SCAN;
            end
         endcase
      end
   end

   assign key_nxt = {row_nxt, col_q};

   always_ff @(posedge CLKIN or posedge ACLR) begin
      if (ACLR) begin
         state_q <= SCAN;
         col_q   <= 2'd0;
         row_q   <= 2'd0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_nxt;
         col_q   <= col_nxt;
         row_q   <= row_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

`ifdef KEYPAD_OVERRUN_EN
   logic overrun_q;

   always_ff @(posedge CLKIN or posedge ACLR) begin
      if (ACLR) begin
         keycode_q  <= 4'd0;
         keyvalid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else if (accept) begin
         if (keyvalid_q && !KEYACK) begin
            overrun_q <= 1'b1;
         end else begin
            keycode_q  <= key_nxt;
            keyvalid_q <= 1'b1;
         end
      end else if (KEYACK && keyvalid_q) begin
         keyvalid_q <= 1'b0;
      end
   end

   assign OVERRUN = overrun_q;
`else
   always_ff @(posedge CLKIN or posedge ACLR) begin
      if (ACLR) begin
         keycode_q  <= 4'd0;
         keyvalid_q <= 1'b0;
      end else if (accept) begin
         keycode_q  <= key_nxt;
         keyvalid_q <= 1'b1;
      end else if (KEYACK && keyvalid_q) begin
         keyvalid_q <= 1'b0;
      end
   end
`endif

   assign COL      = col_drive(col_q);
   assign KEYCODE  = keycode_q;
   assign KEYVALID = keyvalid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random
// row/ack traffic against a press/release reference model.
module tb_keypad_scanner;

   localparam int DT = 4;

   localparam int M_IDLE  = 0;
   localparam int M_PRESS = 1;
   localparam int M_HELD  = 2;
   localparam int M_LETGO = 3;

   logic       CLKIN = 1'b0;
   logic       ACLR = 1'b1;
   logic       SCANCLK = 1'b0;
   logic       KEYACK = 1'b0;
   logic [3:0] ROW = 4'hF;
   logic [3:0] COL;
   logic [3:0] KEYCODE;
   logic       KEYVALID;
`ifdef KEYPAD_OVERRUN_EN
   logic       OVERRUN;
`endif

   int n_checks = 0;
   int n_errors = 0;

   int         m_col, m_mode, m_run, m_row;
   bit         m_valid, m_ovr;
   logic [3:0] m_code;

   keypad_scanner #(.DEBOUNCE_TICKS(DT)) dut (
      .CLKIN    (CLKIN),
      .ACLR     (ACLR),
      .SCANCLK  (SCANCLK),
      .ROW      (ROW),
      .COL      (COL),
      .KEYCODE  (KEYCODE),
      .KEYVALID (KEYVALID),
      .KEYACK   (KEYACK)
`ifdef KEYPAD_OVERRUN_EN
      ,
      .OVERRUN  (OVERRUN)
`endif
   );

   always #5 CLKIN = ~CLKIN;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_col = 0; m_mode = M_IDLE; m_run = 0; m_row = 0;
      m_valid = 0; m_ovr = 0; m_code = 4'd0;
   endfunction

   // One scan tick: key is a contact that stays low DT ticks, release is DT high ticks.
   function automatic void model_tick(input logic [3:0] row, input bit ack);
      bit         acc, hit;
      logic [3:0] k;
      acc = 0;
      hit = (row[m_row] == 1'b0);
      case (m_mode)
         M_IDLE: begin
            if (row != 4'hF) begin
               for (int r = 3; r >= 0; r--) if (!row[r]) m_row = r;
               if (DT == 1) begin acc = 1; m_mode = M_HELD; end
               else begin m_run = 1; m_mode = M_PRESS; end
            end else m_col = (m_col + 1) % 4;
         end
         M_PRESS: begin
            if (hit) begin
               m_run++;
               if (m_run == DT) begin acc = 1; m_mode = M_HELD; end
            end else begin
               m_mode = M_IDLE; m_col = (m_col + 1) % 4;
            end
         end
         M_HELD: begin
            if (!hit) begin
               if (DT == 1) begin m_mode = M_IDLE; m_col = (m_col + 1) % 4; end
               else begin m_run = 1; m_mode = M_LETGO; end
            end
         end
         default: begin
            if (!hit) begin
               m_run++;
               if (m_run == DT) begin m_mode = M_IDLE; m_col = (m_col + 1) % 4; end
            end else m_mode = M_HELD;
         end
      endcase
      k = 4'(m_row * 4 + m_col);
      if (acc) begin
         if (m_valid && !ack) begin
`ifdef KEYPAD_OVERRUN_EN
            m_ovr = 1;
`else
            m_code = k;
`endif
         end else begin
            m_code = k; m_valid = 1;
         end
      end else if (ack && m_valid) m_valid = 0;
   endfunction

   task automatic drive_tick(input bit ack);
      @(negedge CLKIN) SCANCLK = 1'b1;
      @(negedge CLKIN);
      @(negedge CLKIN) KEYACK = ack;
      @(negedge CLKIN) KEYACK = 1'b0;
      @(negedge CLKIN) SCANCLK = 1'b0;
      repeat (3) @(negedge CLKIN);
      model_tick(ROW, ack);
   endtask

   task automatic ack_pulse();
      @(negedge CLKIN) KEYACK = 1'b1;
      @(negedge CLKIN) KEYACK = 1'b0;
      if (m_valid) m_valid = 0;
   endtask

   task automatic test_reset();
      logic [3:0] seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      ACLR = 1'b1;
      repeat (2) @(negedge CLKIN);
      model_reset();
      n_checks++;
      if (COL !== 4'b1110) begin n_errors++; $display("FAIL reset_col: got %b want 1110", COL); end
      n_checks++;
      if (KEYVALID !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", KEYVALID); end
      n_checks++;
      if (KEYCODE !== 4'd0) begin n_errors++; $display("FAIL reset_code: got %h want 0", KEYCODE); end
`ifdef KEYPAD_OVERRUN_EN
      n_checks++;
      if (OVERRUN !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b want 0", OVERRUN); end
`endif
      @(negedge CLKIN) ACLR = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_tick(0);
         n_checks++;
         if (COL !== seq[i]) begin n_errors++; $display("FAIL idle_walk[%0d]: got %b want %b", i, COL, seq[i]); end
      end
   endtask

   task automatic test_clean_press();
      ROW = 4'hF;
      drive_tick(0);
      ROW = 4'b1011;
      for (int i = 1; i <= 4; i++) begin
         drive_tick(0);
         n_checks++;
         if (KEYVALID !== (i == 4)) begin n_errors++; $display("FAIL press_valid[%0d]: got %b want %b", i, KEYVALID, (i == 4)); end
      end
      n_checks++;
      if (KEYCODE !== 4'h9) begin n_errors++; $display("FAIL press_code: got %h want 9", KEYCODE); end
      ack_pulse();
      n_checks++;
      if (KEYVALID !== 1'b0) begin n_errors++; $display("FAIL ack_clear: got %b want 0", KEYVALID); end
      for (int i = 5; i <= 6; i++) begin
         drive_tick(0);
         n_checks++;
         if (KEYVALID !== 1'b0 || COL !== 4'b1101) begin
            n_errors++; $display("FAIL held_norepeat[%0d]: valid %b col %b want 0/1101", i, KEYVALID, COL);
         end
      end
      ROW = 4'hF;
      repeat (4) drive_tick(0);
      n_checks++;
      if (COL !== 4'b1011) begin n_errors++; $display("FAIL release_advance: got %b want 1011", COL); end
   endtask

   task automatic test_bounce();
      ROW = 4'b1110;
      repeat (2) drive_tick(0);
      ROW = 4'hF;
      drive_tick(0);
      n_checks++;
      if (KEYVALID !== 1'b0 || COL !== 4'b0111) begin
         n_errors++; $display("FAIL press_bounce: valid %b col %b want 0/0111", KEYVALID, COL);
      end
      ROW = 4'b1110;
      repeat (4) drive_tick(0);
      n_checks++;
      if (KEYVALID !== 1'b1 || KEYCODE !== 4'h3) begin
         n_errors++; $display("FAIL bounce_key: valid %b code %h want 1/3", KEYVALID, KEYCODE);
      end
      ack_pulse();
      ROW = 4'hF;    repeat (2) drive_tick(0);
      ROW = 4'b1110; drive_tick(0);
      ROW = 4'hF;
      for (int i = 0; i < 4; i++) begin
         drive_tick(0);
         n_checks++;
         if (KEYVALID !== 1'b0) begin n_errors++; $display("FAIL release_bounce[%0d]: got %b want 0", i, KEYVALID); end
      end
      n_checks++;
      if (COL !== 4'b1110) begin n_errors++; $display("FAIL release_bounce_col: got %b want 1110", COL); end
   endtask

   task automatic test_two_rows();
      ROW = 4'hF;
      repeat (3) drive_tick(0);
      ROW = 4'b0101;
      repeat (4) drive_tick(0);
      n_checks++;
      if (KEYVALID !== 1'b1 || KEYCODE !== 4'h7) begin
         n_errors++; $display("FAIL two_rows: valid %b code %h want 1/7", KEYVALID, KEYCODE);
      end
      ack_pulse();
      ROW = 4'hF;
      repeat (4) drive_tick(0);
   endtask

   task automatic test_back_to_back();
      ROW = 4'b1101;
      repeat (4) drive_tick(0);
      ROW = 4'hF;
      repeat (4) drive_tick(0);
      ROW = 4'b0111;
      repeat (4) drive_tick(0);
`ifdef KEYPAD_OVERRUN_EN
      n_checks++;
      if (KEYVALID !== 1'b1 || KEYCODE !== 4'h4 || OVERRUN !== 1'b1) begin
         n_errors++; $display("FAIL overrun_drop: valid %b code %h ovr %b want 1/4/1", KEYVALID, KEYCODE, OVERRUN);
      end
`else
      n_checks++;
      if (KEYVALID !== 1'b1 || KEYCODE !== 4'hD) begin
         n_errors++; $display("FAIL overwrite: valid %b code %h want 1/d", KEYVALID, KEYCODE);
      end
`endif
      ROW = 4'hF;
      repeat (4) drive_tick(0);
      ROW = 4'b1011;
      repeat (3) drive_tick(0);
      drive_tick(1);
      n_checks++;
      if (KEYVALID !== 1'b1 || KEYCODE !== 4'hA) begin
         n_errors++; $display("FAIL ack_with_accept: valid %b code %h want 1/a", KEYVALID, KEYCODE);
      end
      ack_pulse();
      ROW = 4'hF;
      repeat (4) drive_tick(0);
   endtask

   task automatic test_aclr_mid();
      ROW = 4'b1101;
      repeat (2) drive_tick(0);
      @(negedge CLKIN);
      #2 ACLR = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (COL !== 4'b1110 || KEYVALID !== 1'b0 || KEYCODE !== 4'd0) begin
         n_errors++; $display("FAIL aclr_async: col %b valid %b code %h want 1110/0/0", COL, KEYVALID, KEYCODE);
      end
      ROW = 4'hF;
      @(negedge CLKIN) ACLR = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_tick(0);
         n_checks++;
         if (KEYVALID !== 1'b0) begin n_errors++; $display("FAIL aclr_nokey[%0d]: got %b want 0", i, KEYVALID); end
      end
   endtask

   task automatic test_random();
      logic [3:0] exp_col;
      bit         ack;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) >= 6) begin
            if ($urandom_range(0, 1) == 0) ROW = 4'hF;
            else ROW = 4'($urandom_range(0, 14));
         end
         if ($urandom_range(0, 6) == 0) ack_pulse();
         ack = ($urandom_range(0, 4) == 0);
         drive_tick(ack);
         exp_col = 4'b0001 << m_col;
         exp_col = ~exp_col;
         n_checks++;
         if (COL !== exp_col || KEYVALID !== m_valid || (m_valid && KEYCODE !== m_code)) begin
            n_errors++;
            $display("FAIL random[%0d]: col %b valid %b code %h want %b/%b/%h", i, COL, KEYVALID, KEYCODE, exp_col, m_valid, m_code);
         end
`ifdef KEYPAD_OVERRUN_EN
         n_checks++;
         if (OVERRUN !== m_ovr) begin n_errors++; $display("FAIL random_ovr[%0d]: got %b want %b", i, OVERRUN, m_ovr); end
`endif
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_two_rows();
      test_back_to_back();
      test_aclr_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
